// File: rtl/task_tcb.sv
// Task control block: decodes broadcast scheduler commands and tracks one task's
// lifecycle, aged priority, remaining execution hits and run-time watchdog.
module task_tcb #(
  parameter int TASK_ID    = 5,
  parameter int ID_W       = 4,
  parameter int PRIO_W     = 4,
  parameter int HIT_W      = 8,
  parameter int INIT_PRIO  = 0,
  parameter int INIT_HIT   = 128,
  parameter int AGE_PERIOD = 10000,
  parameter int RUN_LIMIT  = 1000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic [15:0]              in_op,
  output logic [ID_W+PRIO_W-1:0]   out_sorter,
  output logic                     exe_flag,
  output logic [2:0]               state_out,
  output logic [HIT_W-1:0]         hit_out,
  output logic                     timeout
);

  localparam logic [2:0] ST_READY      = 3'd0;
  localparam logic [2:0] ST_RUNNING    = 3'd1;
  localparam logic [2:0] ST_SUSPENDED  = 3'd2;
  localparam logic [2:0] ST_WAIT       = 3'd3;
  localparam logic [2:0] ST_TERMINATED = 3'd4;

  localparam logic [3:0] OP_READY   = 4'h1;
  localparam logic [3:0] OP_SUSPEND = 4'h2;
  localparam logic [3:0] OP_WAIT    = 4'h3;
  localparam logic [3:0] OP_KILL    = 4'h4;
  localparam logic [3:0] OP_SETPRIO = 4'h5;
  localparam logic [3:0] OP_SETHIT  = 4'h6;
  localparam logic [3:0] OP_EXECUTE = 4'h7;
  localparam logic [3:0] OP_ADDHIT  = 4'h8;
  localparam logic [3:0] OP_FINISH  = 4'hF;

  localparam int AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam int RUN_W = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT) : 1;

  localparam logic [AGE_W-1:0]  AGE_LAST  = AGE_W'(AGE_PERIOD - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_LIMIT - 1);
  localparam logic [7:0]        ID_BYTE   = 8'(TASK_ID);
  localparam logic [ID_W-1:0]   ID_FIELD  = ID_W'(TASK_ID);
  localparam logic [PRIO_W-1:0] PRIO_MAX  = {PRIO_W{1'b1}};
  localparam logic [HIT_W-1:0]  HIT_MAX   = {HIT_W{1'b1}};
  localparam logic [PRIO_W-1:0] PRIO_INIT = PRIO_W'(INIT_PRIO);
  localparam logic [HIT_W-1:0]  HIT_INIT  = HIT_W'(INIT_HIT);
  localparam logic [ID_W+PRIO_W-1:0] SORTER_INIT =
    (INIT_HIT > 0) ? {ID_FIELD, PRIO_INIT} : '0;

  logic [2:0]              state_q, state_d;
  logic [PRIO_W-1:0]       base_q, base_d;
  logic [PRIO_W-1:0]       eff_q, eff_d;
  logic [HIT_W-1:0]        hit_q, hit_d;
  logic [AGE_W-1:0]        age_q, age_d;
  logic [RUN_W-1:0]        run_q, run_d;
  logic [ID_W+PRIO_W-1:0]  sorter_q, sorter_d;
  logic                    exe_q, exe_d;
  logic                    timeout_q, timeout_d;

  logic [7:0]              cmd_target;
  logic [3:0]              cmd_opcode;
  logic [3:0]              cmd_arg;
  logic                    cmd_accept;
  logic                    cmd_sets_state;
  logic                    cmd_sets_prio;
  logic [HIT_W:0]          hit_sum;

  assign cmd_target = in_op[15:8];
  assign cmd_opcode = in_op[7:4];
  assign cmd_arg    = in_op[3:0];
  assign cmd_accept = in_valid && ((cmd_target == ID_BYTE) || (cmd_target == 8'hFF));
  assign hit_sum    = {1'b0, hit_q} + (HIT_W+1)'(cmd_arg);

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    eff_d          = eff_q;
    hit_d          = hit_q;
    age_d          = '0;
    run_d          = '0;
    timeout_d      = 1'b0;
    cmd_sets_state = 1'b0;
    cmd_sets_prio  = 1'b0;

    // Explicit commands first; illegal ones fall through with no effect.
    if (cmd_accept) begin
      if (cmd_opcode == OP_KILL) begin
        state_d        = ST_TERMINATED;
        cmd_sets_state = 1'b1;
      end else if (state_q != ST_TERMINATED) begin
        case (cmd_opcode)
          OP_READY: begin
            if ((state_q == ST_SUSPENDED) || (state_q == ST_WAIT) ||
                (state_q == ST_RUNNING)) begin
              state_d        = ST_READY;
              cmd_sets_state = 1'b1;
            end
          end
          OP_SUSPEND: begin
            if ((state_q == ST_READY) || (state_q == ST_RUNNING) ||
                (state_q == ST_WAIT)) begin
              state_d        = ST_SUSPENDED;
              cmd_sets_state = 1'b1;
            end
          end
          OP_WAIT: begin
            if ((state_q == ST_READY) || (state_q == ST_RUNNING)) begin
              state_d        = ST_WAIT;
              cmd_sets_state = 1'b1;
            end
          end
          OP_SETPRIO: begin
            base_d        = PRIO_W'(cmd_arg);
            eff_d         = PRIO_W'(cmd_arg);
            cmd_sets_prio = 1'b1;
          end
          OP_SETHIT: begin
            hit_d = HIT_W'(cmd_arg);
          end
          OP_ADDHIT: begin
            hit_d = hit_sum[HIT_W] ? HIT_MAX : hit_sum[HIT_W-1:0];
          end
          OP_EXECUTE: begin
            if ((state_q == ST_READY) && (hit_q != '0)) begin
              state_d        = ST_RUNNING;
              hit_d          = hit_q - 1'b1;
              eff_d          = base_q;
              cmd_sets_state = 1'b1;
            end
          end
          OP_FINISH: begin
            if (state_q == ST_RUNNING) begin
              state_d        = ST_READY;
              cmd_sets_state = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    // Watchdog only acts when no command moved the state this cycle.
    if ((RUN_LIMIT > 0) && (state_q == ST_RUNNING) && !cmd_sets_state) begin
      if (run_q == RUN_LAST) begin
        state_d   = ST_READY;
        timeout_d = 1'b1;
      end else begin
        run_d = run_q + 1'b1;
      end
    end

    // Aging continues across commands that leave state and priority alone.
    if ((state_q == ST_READY) && (state_d == ST_READY) && !cmd_sets_prio) begin
      if (age_q == AGE_LAST) begin
        if (eff_d != PRIO_MAX) begin
          eff_d = eff_d + 1'b1;
        end
      end else begin
        age_d = age_q + 1'b1;
      end
    end

    exe_d    = (state_d == ST_RUNNING);
    sorter_d = ((state_d == ST_READY) && (hit_d != '0)) ? {ID_FIELD, eff_d} : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_READY;
      base_q    <= PRIO_INIT;
      eff_q     <= PRIO_INIT;
      hit_q     <= HIT_INIT;
      age_q     <= '0;
      run_q     <= '0;
      sorter_q  <= SORTER_INIT;
      exe_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      eff_q     <= eff_d;
      hit_q     <= hit_d;
      age_q     <= age_d;
      run_q     <= run_d;
      sorter_q  <= sorter_d;
      exe_q     <= exe_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_sorter = sorter_q;
  assign exe_flag   = exe_q;
  assign state_out  = state_q;
  assign hit_out    = hit_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_task_tcb.sv
// Scoreboard bench for task_tcb: a behavioural task model predicts outputs per cycle,
// a monitor compares them against the DUT one cycle after each drive.
module tb_task_tcb;
  localparam int TID = 5;
  localparam int IDW = 4;
  localparam int PW  = 4;
  localparam int HW  = 8;
  localparam int IP  = 0;
  localparam int IH  = 128;
  localparam int AP  = 4;
  localparam int RL  = 10;

  localparam int S_READY = 0, S_RUN = 1, S_SUSP = 2, S_WAIT = 3, S_TERM = 4;
  localparam int PMAX = (1 << PW) - 1;
  localparam int HMAX = (1 << HW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [15:0]       in_op = 16'h0000;
  logic [IDW+PW-1:0] out_sorter;
  logic              exe_flag;
  logic [2:0]        state_out;
  logic [HW-1:0]     hit_out;
  logic              dut_timeout;

  task_tcb #(
    .TASK_ID(TID), .ID_W(IDW), .PRIO_W(PW), .HIT_W(HW),
    .INIT_PRIO(IP), .INIT_HIT(IH), .AGE_PERIOD(AP), .RUN_LIMIT(RL)
  ) dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_op(in_op),
    .out_sorter(out_sorter), .exe_flag(exe_flag), .state_out(state_out),
    .hit_out(hit_out), .timeout(dut_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sorter;
    int exe;
    int st;
    int hit;
    int tmo;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Task model: lifecycle state, priorities, hits, cycles spent ready/running.
  int m_st, m_base, m_eff, m_hit, m_ready_cyc, m_run_cyc;

  task automatic model_step(input logic r, input logic v, input logic [15:0] op,
                            output exp_t e);
    int prev, tgt, opc, arg, tmo;
    bit moved, prio_written;
    tmo = 0;
    if (r) begin
      m_st = S_READY; m_base = IP; m_eff = IP; m_hit = IH;
      m_ready_cyc = 0; m_run_cyc = 0;
    end else begin
      prev = m_st; moved = 0; prio_written = 0;
      tgt = int'(op[15:8]); opc = int'(op[7:4]); arg = int'(op[3:0]);
      if (v && (tgt == TID || tgt == 255)) begin
        if (opc == 4) begin
          m_st = S_TERM; moved = 1;
        end else if (m_st != S_TERM) begin
          case (opc)
            1: if (m_st == S_SUSP || m_st == S_WAIT || m_st == S_RUN) begin m_st = S_READY; moved = 1; end
            2: if (m_st == S_READY || m_st == S_RUN || m_st == S_WAIT) begin m_st = S_SUSP; moved = 1; end
            3: if (m_st == S_READY || m_st == S_RUN) begin m_st = S_WAIT; moved = 1; end
            5: begin m_base = arg; m_eff = arg; prio_written = 1; end
            6: m_hit = arg;
            8: m_hit = (m_hit + arg > HMAX) ? HMAX : m_hit + arg;
            7: if (m_st == S_READY && m_hit > 0) begin
                 m_st = S_RUN; m_hit = m_hit - 1; m_eff = m_base; m_run_cyc = 0; moved = 1;
               end
            15: if (m_st == S_RUN) begin m_st = S_READY; moved = 1; end
            default: ;
          endcase
        end
      end
      // A task left running RL whole cycles is preempted.
      if (prev == S_RUN && !moved && RL > 0) begin
        m_run_cyc++;
        if (m_run_cyc == RL) begin
          m_st = S_READY; tmo = 1;
        end
      end
      if (m_st != S_RUN) m_run_cyc = 0;
      // Every AP whole cycles spent ready raises the effective priority.
      if (prev == S_READY && m_st == S_READY && !prio_written) begin
        m_ready_cyc++;
        if (m_ready_cyc == AP) begin
          m_ready_cyc = 0;
          if (m_eff < PMAX) m_eff++;
        end
      end else begin
        m_ready_cyc = 0;
      end
    end
    e.sorter = (m_st == S_READY && m_hit > 0) ? ((TID << PW) | m_eff) : 0;
    e.exe    = (m_st == S_RUN) ? 1 : 0;
    e.st     = m_st;
    e.hit    = m_hit;
    e.tmo    = tmo;
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] op);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_op = op;
    model_step(r, v, op, e);
    exp_q.push_back(e);
    if (r || v)
      $display("txn t=%0t rst=%0b valid=%0b op=%h exp_state=%0d exp_hit=%0d exp_bid=%h",
               $time, r, v, op, e.st, e.hit, e.sorter);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at t=%0t: actual %0h required %0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_sorter", int'(out_sorter), e.sorter);
        chk("exe_flag",   int'(exe_flag),   e.exe);
        chk("state_out",  int'(state_out),  e.st);
        chk("hit_out",    int'(hit_out),    e.hit);
        chk("timeout",    int'(dut_timeout), e.tmo);
      end
    end
  end

  int ops[14] = '{1, 2, 3, 5, 6, 7, 8, 15, 0, 7, 7, 15, 1, 9};

  initial begin : stim
    logic [15:0] op;
    logic [7:0]  tgt;
    int roll;
    drive(1'b1, 1'b0, 16'h0000);
    idle(1);
    drive(1'b0, 1'b1, 16'h0557);          // SetPrio 7
    drive(1'b0, 1'b1, 16'h0570);          // Execute
    idle(2);
    drive(1'b0, 1'b1, 16'h05F0);          // Finish
    idle(1);
    drive(1'b0, 1'b1, 16'h055E);          // prio 14, then age to saturation
    idle(9);
    drive(1'b0, 1'b1, 16'h0570);          // run into the watchdog
    idle(13);
    drive(1'b0, 1'b1, 16'h0370);          // other task's Execute, ignored
    drive(1'b0, 1'b1, 16'hFF40);          // broadcast Kill
    drive(1'b0, 1'b1, 16'h0510);
    drive(1'b0, 1'b1, 16'h0570);
    idle(2);
    drive(1'b1, 1'b0, 16'h0000);
    idle(1);
    drive(1'b0, 1'b1, 16'h0561);          // hits = 1
    drive(1'b0, 1'b1, 16'h0570);
    drive(1'b0, 1'b1, 16'h05F0);
    drive(1'b0, 1'b1, 16'h0570);          // no hits left, ignored
    idle(2);
    drive(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 16'h058F);
    drive(1'b0, 1'b1, 16'h0582);          // 250
    drive(1'b0, 1'b1, 16'h058F);          // saturates at 255
    idle(1);

    for (int i = 0; i < 1500; i++) begin
      roll = int'($urandom_range(0, 199));
      if (roll < 3) begin
        drive(1'b1, 1'b0, 16'h0000);
      end else begin
        roll = int'($urandom_range(0, 9));
        if (roll < 6)      tgt = 8'(TID);
        else if (roll < 8) tgt = 8'hFF;
        else begin
          tgt = 8'($urandom_range(0, 254));
          if (tgt == 8'(TID)) tgt = tgt + 8'd1;
        end
        op[15:8] = tgt;
        op[7:4]  = ($urandom_range(0, 99) < 2) ? 4'h4 : 4'(ops[$urandom_range(0, 13)]);
        op[3:0]  = 4'($urandom_range(0, 15));
        drive(1'b0, 1'($urandom_range(0, 1)), op);
      end
    end

    idle(1);
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
